// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and constants for the UART receive deserializer.
// FSM state encoding, parity-type codes, legal oversampling ratios and the sampler's majority vote.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial-line input, frame configuration and parallel-word output of the UART receiver.
// The master drives the line and configuration; the slave (the receiver) returns the word and strobes.
interface uart_rx_deserializer_if #(
    parameter int unsigned WIDTH_DATA = 8,
    parameter int unsigned PRESCALE_W = 6
) ();

    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [WIDTH_DATA-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN,
        output PRESCALE,
        output PAR_EN,
        output PAR_TYP,
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_ERR,
        input  STP_ERR
    );

    modport slave (
        input  RX_IN,
        input  PRESCALE,
        input  PAR_EN,
        input  PAR_TYP,
        output P_DATA,
        output DATA_VALID,
        output PAR_ERR,
        output STP_ERR
    );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter for the UART receiver.
// Produces the bit-end flag, the three mid-bit sample points and the last-data-bit flag.
module uart_rx_edge_bit_counter #(
    parameter int unsigned WIDTH_DATA = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  frame_start,
    input  logic                  count_en,
    input  logic                  bit_inc,
    output logic                  bit_end,
    output logic                  samp_early,
    output logic                  samp_mid,
    output logic                  samp_late,
    output logic                  bit_last
);

    localparam int unsigned BIT_W = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH_DATA - 1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [BIT_W-1:0]      bit_cnt;

    assign half       = prescale >> 1;
    assign bit_end    = (edge_cnt == (prescale - ONE));
    assign samp_early = (edge_cnt == (half - ONE));
    assign samp_mid   = (edge_cnt == half);
    assign samp_late  = (edge_cnt == (half + ONE));
    assign bit_last   = (bit_cnt == LAST_BIT);

    // The cycle that detects a start edge is already edge 0 of that bit, so a new frame loads 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (frame_start) begin
                edge_cnt <= ONE;
            end else if (count_en) begin
                edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
            end else begin
                edge_cnt <= '0;
            end

            if (frame_start) begin
                bit_cnt <= '0;
            end else if (bit_inc && bit_end) begin
                bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: recovers start/data/parity/stop frames from an oversampled line
// and presents the word on P_DATA with a one-cycle DATA_VALID, or a PAR_ERR/STP_ERR strobe.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input logic CLK,
    input logic RST,
    uart_rx_deserializer_if.slave bus
);

    rx_state_t state_q;
    rx_state_t state_d;

    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  s_early_q;
    logic                  s_mid_q;
    logic                  s_late_q;
    logic [WIDTH_DATA-1:0] shift_q;
    logic                  par_bad_q;
    logic [WIDTH_DATA-1:0] p_data_q;
    logic                  valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic frame_start;
    logic count_en;
    logic bit_inc;
    logic shift_en;
    logic load_data;
    logic set_par_bad;
    logic valid_d;
    logic par_err_d;
    logic stp_err_d;

    logic bit_end;
    logic samp_early;
    logic samp_mid;
    logic samp_late;
    logic bit_last;
    logic bit_val;
    logic par_expected;

    uart_rx_edge_bit_counter #(
        .WIDTH_DATA (WIDTH_DATA),
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .CLK         (CLK),
        .RST         (RST),
        .prescale    (prescale_q),
        .frame_start (frame_start),
        .count_en    (count_en),
        .bit_inc     (bit_inc),
        .bit_end     (bit_end),
        .samp_early  (samp_early),
        .samp_mid    (samp_mid),
        .samp_late   (samp_late),
        .bit_last    (bit_last)
    );

    assign bit_val      = majority3(s_early_q, s_mid_q, s_late_q);
    assign par_expected = (^shift_q) ^ (par_typ_q == PAR_ODD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        count_en    = 1'b0;
        bit_inc     = 1'b0;
        shift_en    = 1'b0;
        load_data   = 1'b0;
        set_par_bad = 1'b0;
        valid_d     = 1'b0;
        par_err_d   = 1'b0;
        stp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_d     = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                count_en = 1'b1;
                if (bit_end) begin
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                count_en = 1'b1;
                bit_inc  = 1'b1;
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_last) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                count_en = 1'b1;
                if (bit_end) begin
                    if (bit_val != par_expected) begin
                        par_err_d   = 1'b1;
                        set_par_bad = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                count_en = 1'b1;
                if (bit_end) begin
                    if (!bit_val) begin
                        stp_err_d = 1'b1;
                    end else if (!par_bad_q) begin
                        load_data = 1'b1;
                        valid_d   = 1'b1;
                    end
                    // A low line at stop end is taken as the next start bit's edge 0.
                    if (!bus.RX_IN) begin
                        state_d     = START;
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            s_early_q  <= 1'b1;
            s_mid_q    <= 1'b1;
            s_late_q   <= 1'b1;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            if (frame_start) begin
                prescale_q <= bus.PRESCALE;
                par_en_q   <= bus.PAR_EN;
                par_typ_q  <= bus.PAR_TYP;
                par_bad_q  <= 1'b0;
            end else if (set_par_bad) begin
                par_bad_q <= 1'b1;
            end

            if (samp_early) s_early_q <= bus.RX_IN;
            if (samp_mid)   s_mid_q   <= bus.RX_IN;
            if (samp_late)  s_late_q  <= bus.RX_IN;

            if (shift_en) begin
                shift_q <= {bit_val, shift_q[WIDTH_DATA-1:1]};
            end
            if (load_data) begin
                p_data_q <= shift_q;
            end

            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: a frame driver pushes expected events into a
// scoreboard queue and an independent monitor pops and compares them when strobes appear.
module tb_uart_rx_deserializer;
    import uart_rx_pkg::*;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_deserializer_if #(.WIDTH_DATA(W), .PRESCALE_W(6)) bus ();

    uart_rx_deserializer #(.WIDTH_DATA(W), .PRESCALE_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef enum int {EV_VALID = 0, EV_PAR = 1, EV_STP = 2} ev_kind_t;
    typedef struct {
        ev_kind_t     kind;
        logic [W-1:0] data;
        int           cyc;
    } ev_t;

    ev_t          exp_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] last_good = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    task automatic pop_check(input ev_kind_t kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", int'(kind), -1);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(kind), int'(e.kind));
            check("event_cycle", cyc + 1, e.cyc);
            check("event_p_data", int'(bus.P_DATA), int'(e.data));
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            check("strobe_exclusive", int'(bus.DATA_VALID && (bus.PAR_ERR || bus.STP_ERR)), 0);
            if (bus.PAR_ERR)    pop_check(EV_PAR);
            if (bus.STP_ERR)    pop_check(EV_STP);
            if (bus.DATA_VALID) pop_check(EV_VALID);
        end
    end

    function automatic int pick_prescale();
        case ($urandom_range(0, 2))
            0:       return int'(PRESCALE_8);
            1:       return int'(PRESCALE_16);
            default: return int'(PRESCALE_32);
        endcase
    endfunction

    task automatic drive_bit(input logic b, input int p);
        bus.RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // fault: 0 = clean frame, 1 = inverted parity bit, 2 = stop bit low.
    task automatic send_frame(input int p, input bit pe, input bit pt,
                              input logic [W-1:0] d, input int fault);
        int   t0;
        int   n;
        logic pbit;
        bus.PRESCALE = 6'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        t0   = cyc + 1;
        n    = W + 2 + int'(pe);
        pbit = (^d) ^ pt;
        if (fault == 1) pbit = ~pbit;
        if (pe && fault == 1) begin
            exp_q.push_back('{kind: EV_PAR, data: last_good, cyc: t0 + p * (W + 2)});
        end else if (fault == 2) begin
            exp_q.push_back('{kind: EV_STP, data: last_good, cyc: t0 + p * n});
        end else begin
            exp_q.push_back('{kind: EV_VALID, data: d, cyc: t0 + p * n});
            last_good = d;
        end
        drive_bit(1'b0, p);
        // Configuration changes after the start edge must not affect this frame.
        bus.PRESCALE = 6'(pick_prescale());
        bus.PAR_EN   = 1'($urandom_range(0, 1));
        bus.PAR_TYP  = 1'($urandom_range(0, 1));
        for (int i = 0; i < W; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit((fault == 2) ? 1'b0 : 1'b1, p);
        if (fault == 2) idle(40);
    endtask

    initial begin
        int  p;
        bit  pe;
        int  fault;
        int  r;
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = 6'(PRESCALE_8);
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = PAR_EVEN;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_p_data", int'(bus.P_DATA), 0);
        check("reset_data_valid", int'(bus.DATA_VALID), 0);
        check("reset_par_err", int'(bus.PAR_ERR), 0);
        check("reset_stp_err", int'(bus.STP_ERR), 0);
        RST = 1'b0;
        idle(4);

        send_frame(8, 1'b1, PAR_EVEN, 8'hA5, 0);
        idle(4);
        send_frame(16, 1'b0, PAR_EVEN, 8'h3C, 0);
        send_frame(16, 1'b0, PAR_EVEN, 8'hFF, 0);
        idle(4);
        send_frame(8, 1'b1, PAR_ODD, 8'h01, 1);
        idle(4);
        send_frame(32, 1'b0, PAR_EVEN, 8'h77, 2);

        // Two-cycle glitch; the following start edge arrives exactly at t0+8.
        bus.PRESCALE = 6'(PRESCALE_8);
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = PAR_EVEN;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 6);
        send_frame(8, 1'b1, PAR_EVEN, 8'h5A, 0);
        idle(4);

        // Reset in the middle of data bit 2 of an abandoned frame.
        bus.PRESCALE = 6'(PRESCALE_8);
        bus.PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 4);
        RST       = 1'b1;
        bus.RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midreset_p_data", int'(bus.P_DATA), 0);
        check("midreset_data_valid", int'(bus.DATA_VALID), 0);
        check("midreset_par_err", int'(bus.PAR_ERR), 0);
        check("midreset_stp_err", int'(bus.STP_ERR), 0);
        last_good = '0;
        idle(12);
        send_frame(8, 1'b0, PAR_EVEN, 8'h81, 0);
        idle(4);

        for (int k = 0; k < 30; k++) begin
            p  = pick_prescale();
            pe = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            fault = 0;
            if (r < 2 && pe) fault = 1;
            else if (r == 2) fault = 2;
            send_frame(p, pe, 1'($urandom_range(0, 1)), 8'($urandom), fault);
            idle(int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drain", exp_q.size(), 0);
        idle(64);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side counterpart of the UART transmit serializer: recovers an oversampled asynchronous serial frame (start, WIDTH_DATA data bits LSB-first, optional parity, one stop bit) from RX_IN and presents it as a parallel word with a one-cycle DATA_VALID strobe. It sits between the RX line synchronizer and the register-file/command front end, mirroring the P_DATA/DATA_VALID convention of the transmit path.

## Interface
- WIDTH_DATA, 8, data bits per frame
- PRESCALE_W, 6, width of PRESCALE port
- CLK  input  1  oversampling clock; all logic on rising edge
- RST  input  1  reset; synchronous and active-high
- RX_IN  input  1  serial line, already synchronized to CLK; idle high
- PRESCALE  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even, 1 = odd parity
- P_DATA  output  WIDTH_DATA  last good received word
- DATA_VALID  output  1  one-cycle strobe, P_DATA valid
- PAR_ERR  output  1  one-cycle strobe, parity mismatch
- STP_ERR  output  1  one-cycle strobe, stop bit sampled low

## Operation
- Reset (RST=1 at a rising edge): state IDLE, counters 0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0. Reset mid-frame abandons the frame; no strobes.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- edge_cnt counts 0..PRESCALE-1 per bit; bit_cnt counts data bits 0..WIDTH_DATA-1.
- PRESCALE, PAR_EN, PAR_TYP latched on IDLE->START; changes mid-frame have no effect on that frame.
- Bit sampling: RX_IN captured at edge_cnt = P/2-1, P/2, P/2+1; bit value = majority of the three. Bit end = edge_cnt = P-1.
- IDLE: RX_IN=0 -> START, that cycle counts as edge 0 (edge_cnt<=1).
- START end: sampled 0 -> DATA; sampled 1 (glitch) -> IDLE, no strobes.
- DATA: sampled bit shifted in LSB-first into shift register; at end of bit WIDTH_DATA-1 -> PARITY if PAR_EN else STOP.
- PARITY end: expected = XOR(data) XOR PAR_TYP; mismatch sets internal par_bad and pulses PAR_ERR; always -> STOP.
- STOP end: sampled 0 -> pulse STP_ERR. If stop=1 and not par_bad -> P_DATA<=shift register, pulse DATA_VALID. Otherwise P_DATA holds old value.
- STOP exit: RX_IN=0 in the STOP-end cycle -> START with edge_cnt<=1 (back-to-back frame); else IDLE.
- Error strobes never coincide with DATA_VALID. par_bad cleared on entry to START.

## Timing
- All outputs registered; strobes high exactly one cycle.
- t0 = first cycle RX_IN sampled low in IDLE. DATA_VALID/STP_ERR visible at t0 + P*(WIDTH_DATA+2+PAR_EN) (P=8, parity on, 8 bits: t0+88; parity off: t0+80).
- PAR_ERR visible at t0 + P*(WIDTH_DATA+2).
- Back-to-back frames with zero idle: no lost frame, no extra latency.
- Glitch shorter than P/2-1 cycles at start: return to IDLE at t0+P, no output activity.

## Structure
- Package uart_rx_pkg: FSM state enum, PAR_EVEN/PAR_ODD constants, legal prescale constants.
- One sub-module: uart_rx_edge_bit_counter (edge_cnt/bit_cnt, bit-end and sample-point flags); FSM, majority sampler, shift register and parity check in top.

## Test plan
- P=8, PAR_EN=1 even, frame 0xA5 -> DATA_VALID at t0+88, P_DATA=0xA5, no error strobes.
- P=16, PAR_EN=0, frames 0x3C then 0xFF back-to-back, zero idle -> two DATA_VALID pulses 160 cycles apart, P_DATA 0x3C then 0xFF.
- P=8, odd parity, 0x01 sent with wrong parity bit -> PAR_ERR at t0+80, no DATA_VALID, P_DATA unchanged.
- P=32, stop bit driven low -> STP_ERR at t0+320 (PAR_EN=0), no DATA_VALID.
- P=8, RX_IN low for 2 cycles only -> no strobes, FSM back in IDLE by t0+8; next valid frame 0x5A received correctly.
- RST pulsed at mid-DATA of a frame -> all outputs 0 next cycle, no strobes; following frame 0x81 received correctly.
